// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl
//   Sequencer for a loadable up-counter datapath. It loads the counter with a
//   captured seed, lets it count up to a captured limit, and repeats this for
//   a captured number of passes. A pass count of zero means the sequence runs
//   until it is aborted. It reports busy, done and aborted to the host logic.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst            asynchronous reset, active high
//   i_start          begin a sequence (only looked at in IDLE)
//   i_abort          abandon the sequence; overrides everything else
//   i_seed           counter load value, captured at start
//   i_limit          terminal count, captured at start
//   i_reps           number of passes, captured at start (0 = endless)
//   i_cnt_val        current counter value from the datapath
//   o_cnt_load       datapath loads o_cnt_load_val at the next edge
//   o_cnt_load_val   load value (the captured seed)
//   o_cnt_en         datapath increments by one at the next edge
//   o_busy           high in LOAD and RUN
//   o_done           one-cycle pulse, sequence completed
//   o_aborted        one-cycle pulse, sequence abandoned
//   o_pass_cnt       passes completed in the current sequence
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; pass count of the last sequence is held
// LOAD  | counter loaded with the captured seed this cycle
// RUN   | counting up; the cycle that sees the limit closes the pass
// DONE  | all passes finished, done pulse, back to IDLE

module counter_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int RW    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_seed,
    input  logic [WIDTH-1:0] i_limit,
    input  logic [RW-1:0]    i_reps,
    input  logic [WIDTH-1:0] i_cnt_val,
    output logic             o_cnt_load,
    output logic [WIDTH-1:0] o_cnt_load_val,
    output logic             o_cnt_en,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_aborted,
    output logic [RW-1:0]    o_pass_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_seed;
    logic [WIDTH-1:0] r_limit;
    logic [RW-1:0]    r_reps;
    logic [RW-1:0]    r_pass_cnt;
    logic [RW-1:0]    w_pass_nxt;
    logic             w_capture;
    logic             w_pass_inc;
    logic             w_at_limit;

    assign w_pass_nxt     = r_pass_cnt + RW'(1);
    assign w_at_limit     = (i_cnt_val == r_limit);
    assign o_cnt_load_val = r_seed;
    assign o_pass_cnt     = r_pass_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_seed     <= '0;
            r_limit    <= '0;
            r_reps     <= '0;
            r_pass_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_seed     <= i_seed;
                r_limit    <= i_limit;
                r_reps     <= i_reps;
                r_pass_cnt <= '0;
            end else if (w_pass_inc) begin
                r_pass_cnt <= w_pass_nxt;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_pass_inc  = 1'b0;
        o_cnt_load  = 1'b0;
        o_cnt_en    = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_aborted   = 1'b0;

        case (r_state)
            S_IDLE: begin
                // abort together with start keeps us idle without a pulse
                if (i_start && !i_abort) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                o_busy = 1'b1;
                if (i_abort) begin
                    o_aborted   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    o_cnt_load  = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                o_busy = 1'b1;
                if (i_abort) begin
                    o_aborted   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_at_limit) begin
                    // compare cycle: counter holds, pass is closed
                    w_pass_inc = 1'b1;
                    if ((r_reps != '0) && (w_pass_nxt == r_reps)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end else begin
                    o_cnt_en = 1'b1;
                end
            end
            S_DONE: begin
                if (i_abort) begin
                    o_aborted = 1'b1;
                end else begin
                    o_done = 1'b1;
                end
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
